// File: rtl/victim_fill_ctrl.sv
// Miss sequencer between L1, a 4-entry victim cache and main memory; one miss in flight at a time.
// Define VICTIM_STATS_EN to add saturating hit/miss/write-back counters.
module victim_fill_ctrl #(
    parameter int unsigned ADDR_BITS   = 32,
    parameter int unsigned LINE_BITS   = 256,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 evict_valid,
    input  logic                 evict_dirty,
    input  logic [ADDR_BITS-1:0] evict_addr,
    input  logic [LINE_BITS-1:0] evict_data,

    output logic                 vc_lookup,
    output logic                 vc_fill,
    output logic [ADDR_BITS-1:0] vc_addr,
    output logic [LINE_BITS-1:0] vc_fill_data,
    input  logic                 vc_hit,
    input  logic [LINE_BITS-1:0] vc_line,
    input  logic                 vc_disp_valid,
    input  logic                 vc_disp_dirty,
    input  logic [ADDR_BITS-1:0] vc_disp_addr,
    input  logic [LINE_BITS-1:0] vc_disp_data,

    output logic                 mem_rd_req,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic                 mem_rd_valid,
    input  logic [LINE_BITS-1:0] mem_rd_data,
    output logic                 mem_wr_req,
    output logic [ADDR_BITS-1:0] mem_wr_addr,
    output logic [LINE_BITS-1:0] mem_wr_data,
    input  logic                 mem_wr_ack,

    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_data,
    output logic                 resp_from_vc
`ifdef VICTIM_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses,
    output logic [31:0]          stat_wbs
`endif
);

    localparam logic [ADDR_BITS-1:0] LineMask =
        {{(ADDR_BITS - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [3:0] {
        StIdle,
        StProbe,
        StCheck,
        StMemReq,
        StMemWait,
        StFill,
        StDisp,
        StWb,
        StResp
    } state_e;

    state_e               state_q;

    logic [ADDR_BITS-1:0] line_addr_q;
    logic                 evict_valid_q;
    logic                 evict_dirty_q;
    logic [ADDR_BITS-1:0] evict_addr_q;
    logic [LINE_BITS-1:0] evict_data_q;

    logic                 vc_lookup_q;
    logic                 vc_fill_q;
    logic [ADDR_BITS-1:0] vc_addr_q;
    logic                 mem_rd_req_q;
    logic [ADDR_BITS-1:0] mem_rd_addr_q;
    logic                 mem_wr_req_q;
    logic [ADDR_BITS-1:0] mem_wr_addr_q;
    logic [LINE_BITS-1:0] mem_wr_data_q;
    logic                 resp_valid_q;
    logic [LINE_BITS-1:0] resp_data_q;
    logic                 resp_from_vc_q;

    // The dirty flag travels with the fill data outside this block.
    logic                 unused_evict_dirty;
    assign unused_evict_dirty = evict_dirty_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= StIdle;
            line_addr_q    <= '0;
            evict_valid_q  <= 1'b0;
            evict_dirty_q  <= 1'b0;
            evict_addr_q   <= '0;
            evict_data_q   <= '0;
            vc_lookup_q    <= 1'b0;
            vc_fill_q      <= 1'b0;
            vc_addr_q      <= '0;
            mem_rd_req_q   <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_req_q   <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_from_vc_q <= 1'b0;
        end else begin
            vc_lookup_q  <= 1'b0;
            vc_fill_q    <= 1'b0;
            mem_rd_req_q <= 1'b0;
            resp_valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        line_addr_q   <= req_addr & LineMask;
                        evict_valid_q <= evict_valid;
                        evict_dirty_q <= evict_dirty;
                        evict_addr_q  <= evict_addr & LineMask;
                        evict_data_q  <= evict_data;
                        vc_lookup_q   <= 1'b1;
                        vc_addr_q     <= req_addr & LineMask;
                        state_q       <= StProbe;
                    end
                end

                StProbe: begin
                    state_q <= StCheck;
                end

                StCheck: begin
                    if (vc_hit) begin
                        resp_data_q    <= vc_line;
                        resp_from_vc_q <= 1'b1;
                        if (evict_valid_q) begin
                            vc_fill_q <= 1'b1;
                            vc_addr_q <= evict_addr_q;
                            state_q   <= StFill;
                        end else begin
                            state_q <= StResp;
                        end
                    end else begin
                        mem_rd_req_q  <= 1'b1;
                        mem_rd_addr_q <= line_addr_q;
                        state_q       <= StMemReq;
                    end
                end

                // Read data may already arrive in the request cycle.
                StMemReq, StMemWait: begin
                    if (mem_rd_valid) begin
                        resp_data_q    <= mem_rd_data;
                        resp_from_vc_q <= 1'b0;
                        if (evict_valid_q) begin
                            vc_fill_q <= 1'b1;
                            vc_addr_q <= evict_addr_q;
                            state_q   <= StFill;
                        end else begin
                            state_q <= StResp;
                        end
                    end else begin
                        state_q <= StMemWait;
                    end
                end

                StFill: begin
                    state_q <= StDisp;
                end

                StDisp: begin
                    if (vc_disp_valid && vc_disp_dirty) begin
                        mem_wr_req_q  <= 1'b1;
                        mem_wr_addr_q <= vc_disp_addr;
                        mem_wr_data_q <= vc_disp_data;
                        state_q       <= StWb;
                    end else begin
                        state_q <= StResp;
                    end
                end

                StWb: begin
                    if (mem_wr_ack) begin
                        mem_wr_req_q <= 1'b0;
                        state_q      <= StResp;
                    end
                end

                StResp: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign vc_lookup    = vc_lookup_q;
    assign vc_fill      = vc_fill_q;
    assign vc_addr      = vc_addr_q;
    assign vc_fill_data = evict_data_q;
    assign mem_rd_req   = mem_rd_req_q;
    assign mem_rd_addr  = mem_rd_addr_q;
    assign mem_wr_req   = mem_wr_req_q;
    assign mem_wr_addr  = mem_wr_addr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_from_vc = resp_from_vc_q;

`ifdef VICTIM_STATS_EN
    logic [31:0] stat_hits_q;
    logic [31:0] stat_misses_q;
    logic [31:0] stat_wbs_q;
    logic        hit_evt;
    logic        miss_evt;
    logic        wb_evt;

    assign hit_evt  = (state_q == StCheck) && vc_hit;
    assign miss_evt = (state_q == StCheck) && !vc_hit;
    assign wb_evt   = (state_q == StWb) && mem_wr_ack;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_wbs_q    <= '0;
        end else begin
            if (hit_evt && (stat_hits_q != 32'hFFFF_FFFF)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (miss_evt && (stat_misses_q != 32'hFFFF_FFFF)) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
            if (wb_evt && (stat_wbs_q != 32'hFFFF_FFFF)) begin
                stat_wbs_q <= stat_wbs_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_wbs    = stat_wbs_q;
`endif

endmodule

// File: tb/tb_victim_fill_ctrl.sv
// Randomised bench for victim_fill_ctrl: the bench plays victim cache and memory and checks
// each transaction against latency/data rules computed from the transaction's parameters.
module tb_victim_fill_ctrl;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         req_valid, req_ready;
    logic [31:0]  req_addr;
    logic         evict_valid, evict_dirty;
    logic [31:0]  evict_addr;
    logic [255:0] evict_data;
    logic         vc_lookup, vc_fill;
    logic [31:0]  vc_addr;
    logic [255:0] vc_fill_data;
    logic         vc_hit;
    logic [255:0] vc_line;
    logic         vc_disp_valid, vc_disp_dirty;
    logic [31:0]  vc_disp_addr;
    logic [255:0] vc_disp_data;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_valid;
    logic [255:0] mem_rd_data;
    logic         mem_wr_req;
    logic [31:0]  mem_wr_addr;
    logic [255:0] mem_wr_data;
    logic         mem_wr_ack;
    logic         resp_valid;
    logic [255:0] resp_data;
    logic         resp_from_vc;
`ifdef VICTIM_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_wbs;
`endif

    always #5 CLK = ~CLK;

    victim_fill_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .evict_valid  (evict_valid),
        .evict_dirty  (evict_dirty),
        .evict_addr   (evict_addr),
        .evict_data   (evict_data),
        .vc_lookup    (vc_lookup),
        .vc_fill      (vc_fill),
        .vc_addr      (vc_addr),
        .vc_fill_data (vc_fill_data),
        .vc_hit       (vc_hit),
        .vc_line      (vc_line),
        .vc_disp_valid(vc_disp_valid),
        .vc_disp_dirty(vc_disp_dirty),
        .vc_disp_addr (vc_disp_addr),
        .vc_disp_data (vc_disp_data),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_from_vc (resp_from_vc)
`ifdef VICTIM_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses),
        .stat_wbs     (stat_wbs)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered over one transaction.
    int           obs_lat, obs_lookups, obs_fills, obs_rd_reqs, obs_wr_cycles, obs_resps;
    logic [31:0]  obs_lookup_addr, obs_fill_addr, obs_rd_addr, obs_wr_addr;
    logic [255:0] obs_fill_data, obs_wr_data, obs_resp_data;
    logic         obs_from_vc;
    bit           obs_ready_ok, obs_excl_ok, obs_wr_stable;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'h1F;
    endfunction

    // Cycles from the accept edge until resp_valid is high.
    function automatic int exp_lat(input bit hit, input bit evict, input bit wb,
                                   input int mem_lat, input int wb_lat);
        int t;
        t = hit ? 3 : 4 + mem_lat;
        if (evict) t += 2;
        if (wb) t += wb_lat;
        return t;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0; req_addr = '0;
        evict_valid = 1'b0; evict_dirty = 1'b0; evict_addr = '0; evict_data = '0;
        vc_hit = 1'b0; vc_line = '0;
        vc_disp_valid = 1'b0; vc_disp_dirty = 1'b0; vc_disp_addr = '0; vc_disp_data = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
    endtask

    task automatic run_txn(input bit hit, input bit evict, input bit dvalid, input bit ddirty,
                           input int mem_lat, input int wb_lat,
                           input logic [31:0] raddr, input logic [31:0] eaddr,
                           input logic [31:0] daddr, input logic [255:0] vline,
                           input logic [255:0] mline, input logic [255:0] edata,
                           input logic [255:0] ddata);
        int c, rd_c;
        bit prev_lookup, prev_fill, done;
        obs_lat = -1; obs_lookups = 0; obs_fills = 0; obs_rd_reqs = 0; obs_wr_cycles = 0;
        obs_resps = 0; obs_ready_ok = 1; obs_excl_ok = 1; obs_wr_stable = 1;
        obs_lookup_addr = '0; obs_fill_addr = '0; obs_rd_addr = '0; obs_wr_addr = '0;
        obs_fill_data = '0; obs_wr_data = '0; obs_resp_data = '0; obs_from_vc = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_addr = raddr;
        evict_valid = evict; evict_dirty = 1'($urandom); evict_addr = eaddr; evict_data = edata;
        c = 0; rd_c = -1; prev_lookup = 0; prev_fill = 0; done = 0;
        while (!done && c < 80) begin
            @(negedge CLK);
            if (resp_valid) begin
                obs_resps++; obs_lat = c; obs_resp_data = resp_data;
                obs_from_vc = resp_from_vc; done = 1;
            end else if (req_ready) begin
                obs_ready_ok = 0;
            end
            if (int'(vc_lookup) + int'(vc_fill) + int'(mem_rd_req) > 1) obs_excl_ok = 0;
            if (vc_lookup) begin obs_lookups++; obs_lookup_addr = vc_addr; end
            if (vc_fill) begin
                obs_fills++; obs_fill_addr = vc_addr; obs_fill_data = vc_fill_data;
            end
            if (mem_rd_req) begin obs_rd_reqs++; obs_rd_addr = mem_rd_addr; rd_c = c; end
            if (mem_wr_req) begin
                if (obs_wr_cycles > 0 && (mem_wr_addr !== obs_wr_addr ||
                                          mem_wr_data !== obs_wr_data)) obs_wr_stable = 0;
                obs_wr_cycles++; obs_wr_addr = mem_wr_addr; obs_wr_data = mem_wr_data;
            end
            // Busy-time noise on the request side must be ignored.
            req_valid = done ? 1'b0 : 1'($urandom);
            req_addr = $urandom; evict_valid = 1'($urandom); evict_dirty = 1'($urandom);
            evict_addr = $urandom; evict_data = rand_line();
            vc_hit = prev_lookup ? hit : 1'($urandom);
            vc_line = prev_lookup ? vline : rand_line();
            vc_disp_valid = prev_fill ? dvalid : 1'($urandom);
            vc_disp_dirty = prev_fill ? ddirty : 1'($urandom);
            vc_disp_addr = prev_fill ? daddr : $urandom;
            vc_disp_data = prev_fill ? ddata : rand_line();
            mem_rd_valid = (rd_c >= 0) && (c == rd_c + mem_lat);
            mem_rd_data = mem_rd_valid ? mline : rand_line();
            mem_wr_ack = mem_wr_req && (obs_wr_cycles == wb_lat);
            prev_lookup = vc_lookup; prev_fill = vc_fill;
            c++;
        end
        req_valid = 1'b0; mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid = 1'b1;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({vc_lookup, vc_fill, mem_rd_req, mem_wr_req, resp_valid, resp_from_vc} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b required 000000",
                     {vc_lookup, vc_fill, mem_rd_req, mem_wr_req, resp_valid, resp_from_vc});
        end
        checks++;
        if ((vc_addr | mem_rd_addr | mem_wr_addr) !== 32'h0 ||
            (resp_data | vc_fill_data | mem_wr_data) !== 256'h0) begin
            errors++;
            $display("FAIL reset_data got vc_addr=%h rd=%h wr=%h required all zero",
                     vc_addr, mem_rd_addr, mem_wr_addr);
        end
        req_valid = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_vc_hit();
        logic [255:0] line_ab;
        line_ab = {32{8'hAB}};
        run_txn(1, 0, 0, 0, 0, 1, 32'h0000_1234, 32'h0, 32'h0, line_ab, rand_line(),
                rand_line(), rand_line());
        checks++;
        if (obs_lookup_addr !== 32'h0000_1220) begin
            errors++; $display("FAIL hit_vc_addr got %h required 00001220", obs_lookup_addr);
        end
        checks++;
        if (obs_lat !== 3) begin
            errors++; $display("FAIL hit_latency got %0d required 3", obs_lat);
        end
        checks++;
        if (obs_resp_data !== line_ab || obs_from_vc !== 1'b1) begin
            errors++;
            $display("FAIL hit_resp got data=%h from_vc=%b required ab..ab/1",
                     obs_resp_data, obs_from_vc);
        end
    endtask

    task automatic test_miss();
        logic [255:0] line_55;
        line_55 = {32{8'h55}};
        run_txn(0, 0, 0, 0, 5, 1, 32'h0000_2000, 32'h0, 32'h0, rand_line(), line_55,
                rand_line(), rand_line());
        checks++;
        if (obs_rd_reqs !== 1 || obs_rd_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL miss_rd_req got %0d pulses addr %h required 1 at 00002000",
                     obs_rd_reqs, obs_rd_addr);
        end
        checks++;
        if (obs_resp_data !== line_55 || obs_from_vc !== 1'b0) begin
            errors++;
            $display("FAIL miss_resp got data=%h from_vc=%b required 55..55/0",
                     obs_resp_data, obs_from_vc);
        end
        checks++;
        if (obs_ready_ok !== 1'b1 || obs_lat !== 9) begin
            errors++;
            $display("FAIL miss_ready_lat got ready_low=%b lat=%0d required 1/9",
                     obs_ready_ok, obs_lat);
        end
    endtask

    task automatic test_miss_evict_wb();
        logic [255:0] dd;
        dd = rand_line();
        run_txn(0, 1, 1, 1, 2, 3, 32'h0000_5040, 32'h0000_3010, 32'h0000_4000, rand_line(),
                rand_line(), rand_line(), dd);
        checks++;
        if (obs_fills !== 1 || obs_fill_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL wb_fill got %0d fills addr %h required 1 at 00003000",
                     obs_fills, obs_fill_addr);
        end
        checks++;
        if (obs_wr_cycles !== 3 || obs_wr_addr !== 32'h0000_4000 || obs_wr_data !== dd ||
            obs_wr_stable !== 1'b1) begin
            errors++;
            $display("FAIL wb_write got cycles=%0d addr=%h stable=%b required 3/00004000/1",
                     obs_wr_cycles, obs_wr_addr, obs_wr_stable);
        end
        checks++;
        if (obs_lat !== exp_lat(0, 1, 1, 2, 3)) begin
            errors++;
            $display("FAIL wb_latency got %0d required %0d", obs_lat, exp_lat(0, 1, 1, 2, 3));
        end
    endtask

    task automatic test_hit_evict_clean();
        run_txn(1, 1, 1, 0, 0, 1, 32'h0000_6000, 32'h0000_7020, 32'h0000_8000, rand_line(),
                rand_line(), rand_line(), rand_line());
        checks++;
        if (obs_wr_cycles !== 0) begin
            errors++; $display("FAIL clean_no_wb got %0d write cycles required 0", obs_wr_cycles);
        end
        checks++;
        if (obs_lat !== 5) begin
            errors++; $display("FAIL clean_latency got %0d required 5", obs_lat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        @(negedge CLK);
        idle_inputs();
        req_valid = 1'b1; req_addr = 32'h0000_9000;
        @(negedge CLK);
        req_valid = 1'b0;
        n = 0;
        while (!mem_rd_req && n < 10) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (mem_rd_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_reach_mem got mem_rd_req=%b required 1", mem_rd_req);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        checks++;
        if ({vc_lookup, vc_fill, mem_rd_req, mem_wr_req, resp_valid, resp_from_vc} !== 6'b0 ||
            (vc_addr | mem_rd_addr) !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got rd_req=%b rd_addr=%h required 0/0",
                     mem_rd_req, mem_rd_addr);
        end
        RST_N = 1'b1;
        mem_rd_valid = 1'b1; mem_rd_data = rand_line();
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got %b required 1", req_ready);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid || vc_lookup || vc_fill || mem_rd_req || mem_wr_req) bad++;
            @(negedge CLK);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rstmid_quiet got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            bit hit, evict, dvalid, ddirty, wb;
            int ml, wl, el;
            logic [31:0] ra, ea, da;
            logic [255:0] vl, mlin, ed, dd;
            hit = 1'($urandom); evict = 1'($urandom);
            dvalid = 1'($urandom); ddirty = 1'($urandom);
            ml = $urandom_range(0, 6); wl = $urandom_range(1, 4);
            ra = $urandom; ea = $urandom; da = $urandom;
            vl = rand_line(); mlin = rand_line(); ed = rand_line(); dd = rand_line();
            wb = evict && dvalid && ddirty;
            el = exp_lat(hit, evict, wb, ml, wl);
            run_txn(hit, evict, dvalid, ddirty, ml, wl, ra, ea, da, vl, mlin, ed, dd);
            checks++;
            if (obs_lat !== el) begin
                errors++; $display("FAIL rnd%0d_latency got %0d required %0d", k, obs_lat, el);
            end
            checks++;
            if (obs_resp_data !== (hit ? vl : mlin) || obs_from_vc !== hit) begin
                errors++;
                $display("FAIL rnd%0d_resp got from_vc=%b data=%h required from_vc=%b",
                         k, obs_from_vc, obs_resp_data, hit);
            end
            checks++;
            if (obs_lookups !== 1 || obs_lookup_addr !== line_of(ra)) begin
                errors++;
                $display("FAIL rnd%0d_lookup got %0d at %h required 1 at %h",
                         k, obs_lookups, obs_lookup_addr, line_of(ra));
            end
            checks++;
            if (obs_rd_reqs !== (hit ? 0 : 1) || (!hit && obs_rd_addr !== line_of(ra))) begin
                errors++;
                $display("FAIL rnd%0d_memrd got %0d at %h required %0d at %h",
                         k, obs_rd_reqs, obs_rd_addr, hit ? 0 : 1, line_of(ra));
            end
            checks++;
            if (obs_fills !== int'(evict) ||
                (evict && (obs_fill_addr !== line_of(ea) || obs_fill_data !== ed))) begin
                errors++;
                $display("FAIL rnd%0d_fill got %0d at %h required %0d at %h",
                         k, obs_fills, obs_fill_addr, evict, line_of(ea));
            end
            checks++;
            if (obs_wr_cycles !== (wb ? wl : 0) ||
                (wb && (obs_wr_addr !== da || obs_wr_data !== dd || !obs_wr_stable))) begin
                errors++;
                $display("FAIL rnd%0d_wb got %0d cycles at %h required %0d at %h",
                         k, obs_wr_cycles, obs_wr_addr, wb ? wl : 0, da);
            end
            checks++;
            if (!obs_ready_ok || !obs_excl_ok || obs_resps !== 1) begin
                errors++;
                $display("FAIL rnd%0d_proto got ready_ok=%b excl_ok=%b resps=%0d required 1/1/1",
                         k, obs_ready_ok, obs_excl_ok, obs_resps);
            end
        end
    endtask

`ifdef VICTIM_STATS_EN
    task automatic test_stats();
        @(negedge CLK);
        idle_inputs();
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        run_txn(1, 0, 0, 0, 0, 1, $urandom, 32'h0, 32'h0, rand_line(), rand_line(),
                rand_line(), rand_line());
        run_txn(1, 0, 0, 0, 0, 1, $urandom, 32'h0, 32'h0, rand_line(), rand_line(),
                rand_line(), rand_line());
        run_txn(0, 1, 1, 1, 1, 2, $urandom, $urandom, $urandom, rand_line(), rand_line(),
                rand_line(), rand_line());
        checks++;
        if (stat_hits !== 32'd2 || stat_misses !== 32'd1 || stat_wbs !== 32'd1) begin
            errors++;
            $display("FAIL stats got hits=%0d misses=%0d wbs=%0d required 2/1/1",
                     stat_hits, stat_misses, stat_wbs);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        RST_N = 1'b0;
        test_reset();
        test_vc_hit();
        test_miss();
        test_miss_evict_wb();
        test_hit_evict_clean();
        test_reset_mid();
        test_random();
`ifdef VICTIM_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
